frame_stream_ctrl: RTL and testbench

Frame sequencer between the input pixel FIFO and the output pixel FIFO of the streaming system. On start, moves exactly IMG_WIDTH*IMG_HEIGHT pixel words from the input FIFO (first-word-fall-through) to the output FIFO through a one-entry registered output stage. Generates column/row position and frame sideband flags, then signals completion. Pixels are 24-bit RGB packed in the upper bytes of a 32-bit word, with the low byte as padding.

---
 rtl/frame_stream_ctrl.sv | 140 ++++++++++++++
 tb/tb_frame_stream_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_stream_ctrl.sv
// Frame sequencer: moves W*H pixel words from input FIFO to output FIFO with position flags.
// Define FRAME_CHECKSUM_EN to build the 32-bit wrapping checksum of written words.
module frame_stream_ctrl #(
  parameter int DWIDTH = 32,
  parameter int IMG_WIDTH = 720,
  parameter int IMG_HEIGHT = 540,
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [DWIDTH-1:0] in_dout,
  input  logic              in_empty,
  output logic              in_rd_en,
  output logic [DWIDTH-1:0] out_din,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [CW-1:0]     col,
  output logic [RW-1:0]     row,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic [31:0]       checksum
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int NW = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, state_nxt;
  logic valid;
  logic load, accept, last_rd, last_col;
  logic [NW-1:0] rd_cnt;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] rd_row;

  // the pad byte of the input word is intentionally discarded
  logic unused_pad;
  assign unused_pad = ^in_dout[7:0];

  assign last_rd = (rd_cnt == NW'(TOTAL - 1));
  assign last_col = (rd_col == CW'(IMG_WIDTH - 1));
  assign out_wr_en = valid && !out_full;
  assign in_rd_en = load;

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy = 1'b0;
    done = 1'b0;
    load = 1'b0;
    accept = 1'b0;
    unique case (state)
      IDLE: begin
        accept = start;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        load = !in_empty && (!valid || !out_full)
               && (rd_cnt < NW'(TOTAL));
        if (load && last_rd) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (out_wr_en && eof) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // a load in the same cycle as a write replaces the word, keeping 1 word/cycle
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid <= 1'b0;
      out_din <= '0;
      col <= '0;
      row <= '0;
      sof <= 1'b0;
      eol <= 1'b0;
      eof <= 1'b0;
      rd_cnt <= '0;
      rd_col <= '0;
      rd_row <= '0;
    end else begin
      if (accept) begin
        rd_cnt <= '0;
        rd_col <= '0;
        rd_row <= '0;
        col <= '0;
        row <= '0;
      end
      if (load) begin
        valid <= 1'b1;
        out_din <= {in_dout[DWIDTH-1:8], 8'h00};
        col <= rd_col;
        row <= rd_row;
        sof <= (rd_cnt == '0);
        eol <= last_col;
        eof <= last_rd;
        rd_cnt <= rd_cnt + NW'(1);
        if (last_col) begin
          rd_col <= '0;
          rd_row <= rd_row + RW'(1);
        end else begin
          rd_col <= rd_col + CW'(1);
        end
      end else if (out_wr_en) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  logic [31:0] sum;

  always_ff @(posedge clock) begin
    if (!reset) sum <= '0;
    else if (accept) sum <= '0;
    else if (out_wr_en) sum <= sum + 32'(out_din);
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Scoreboard bench for frame_stream_ctrl on a 4x3 frame.
// Expected pixels come from a frame model; a monitor pops them on each write.
module tb_frame_stream_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct {
    logic [31:0] d;
    int c;
    int r;
    bit s;
    bit el;
    bit ef;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic in_empty = 1'b1;
  logic out_full = 1'b0;
  logic [31:0] in_dout = '0;
  logic busy, done, in_rd_en, out_wr_en, sof, eol, eof;
  logic [31:0] out_din, checksum;
  logic [1:0] col, row;

  always #5 clock = ~clock;

  frame_stream_ctrl #(
    .DWIDTH(32), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
    .col(col), .row(row), .sof(sof), .eol(eol), .eof(eof),
    .checksum(checksum)
  );

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = -100;
  logic [31:0] sum_model = '0;
  logic [31:0] in_q[$];
  exp_t exp_q[$];
  bit rand_full = 0;
  bit rand_starve = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      cyc++;
      if (out_wr_en === 1'b1) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          flag_fail("unexpected write");
        end else begin
          e = exp_q.pop_front();
          if (e.s) first_wr_cyc = cyc;
          check("data", out_din, e.d);
          check("col", 32'(col), e.c);
          check("row", 32'(row), e.r);
          check("sof/eol/eof", 32'({sof, eol, eof}),
                32'({e.s, e.el, e.ef}));
          sum_model += e.d;
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("busy at done", 32'(busy), 0);
        check("done latency", cyc - last_wr_cyc, 1);
        check("pending at done", exp_q.size(), 0);
`ifdef FRAME_CHECKSUM_EN
        check("checksum at done", checksum, sum_model);
`else
        check("checksum at done", checksum, 0);
`endif
      end
    end
  end

  // input/output FIFO models
  initial begin
    logic p;
    bit starve;
    forever begin
      @(negedge clock);
      p = in_rd_en;
      @(posedge clock);
      #2;
      if (p === 1'b1) begin
        rd_cnt++;
        if (in_q.size() == 0) flag_fail("pop of empty input");
        else void'(in_q.pop_front());
      end
      if (rand_full) out_full = ($urandom_range(0, 2) == 0);
      starve = rand_starve && ($urandom_range(0, 3) == 0);
      in_empty = starve || (in_q.size() == 0);
      in_dout = (in_q.size() != 0) ? in_q[0] : 32'h0;
    end
  end

  task automatic load_frame(input int nwords, input int mode);
    exp_t e;
    logic [31:0] w;
    for (int k = 0; k < nwords; k++) begin
      case (mode)
        0: w = 32'h01020300 + 32'(k << 8);
        1: begin w = $urandom(); w[7:0] = 8'hAB; end
        2: w = 32'h00000100;
        default: w = $urandom();
      endcase
      in_q.push_back(w);
      if (k < N) begin
        e.d = {w[31:8], 8'h00};
        e.c = k % W;
        e.r = k / W;
        e.s = (k == 0);
        e.el = ((k % W) == W - 1);
        e.ef = (k == N - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic pulse_start(input bit new_frame);
    @(posedge clock);
    #1;
    start = 1'b1;
    if (new_frame) sum_model = '0;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int c0 = done_cnt;
    int n = 0;
    while (done_cnt == c0 && n < bound) begin
      @(posedge clock);
      n++;
    end
    if (done_cnt == c0) flag_fail("done timeout");
  endtask

  task automatic wait_writes(input int target, input int bound);
    int n = 0;
    while (wr_cnt < target && n < bound) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (wr_cnt < target) flag_fail("write timeout");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset in_rd_en", 32'(in_rd_en), 0);
    check("reset out_wr_en", 32'(out_wr_en), 0);
    check("reset out_din", out_din, 0);
    check("reset pos/flags", 32'({col, row, sof, eol, eof}), 0);
    check("reset checksum", checksum, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // basic frame, back-to-back writes
    w0 = wr_cnt;
    load_frame(N, 0);
    pulse_start(1);
    wait_done(200);
    check("basic writes", wr_cnt - w0, N);
    check("burst span", last_wr_cyc - first_wr_cyc, N - 1);
    check("input drained", in_q.size(), 0);

    // pad byte must be cleared
    load_frame(N, 1);
    pulse_start(1);
    wait_done(200);

    // output stall while pixel 5 sits in the stage
    w0 = wr_cnt;
    load_frame(N, 0);
    pulse_start(1);
    wait_writes(w0 + 5, 100);
    out_full = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("stall data", out_din, 32'h01020800);
      check("stall col", 32'(col), 1);
      check("stall row", 32'(row), 1);
      check("stall in_rd_en", 32'(in_rd_en), 0);
      check("stall out_wr_en", 32'(out_wr_en), 0);
    end
    @(posedge clock);
    #1;
    out_full = 1'b0;
    wait_done(200);
    check("stall writes", wr_cnt - w0, N);

    // surplus input words stay in the FIFO
    r0 = rd_cnt;
    d0 = done_cnt;
    load_frame(N + 3, 0);
    pulse_start(1);
    wait_done(200);
    repeat (10) @(posedge clock);
    check("surplus pops", rd_cnt - r0, N);
    check("surplus left", in_q.size(), 3);
    check("surplus done", done_cnt - d0, 1);
    in_q.delete();
    repeat (2) @(posedge clock);

    // reset mid-frame, then a fresh frame
    w0 = wr_cnt;
    load_frame(N, 0);
    pulse_start(1);
    wait_writes(w0 + 7, 100);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #3;
    exp_q.delete();
    in_q.delete();
    repeat (4) begin
      @(negedge clock);
      check("post-reset busy", 32'(busy), 0);
      check("post-reset strobes", 32'({in_rd_en, out_wr_en}), 0);
    end
    load_frame(N, 3);
    pulse_start(1);
    wait_done(200);

    // checksum frame
    load_frame(N, 2);
    pulse_start(1);
    wait_done(200);
    repeat (5) @(posedge clock);
`ifdef FRAME_CHECKSUM_EN
    check("checksum hold", checksum, 32'h00000C00);
`else
    check("checksum off", checksum, 0);
`endif

    // randomized back-pressure, starvation and spurious starts
    rand_full = 1;
    rand_starve = 1;
    d0 = done_cnt;
    for (int f = 0; f < 6; f++) begin
      load_frame(N, 3);
      pulse_start(1);
      repeat ($urandom_range(1, 8)) @(posedge clock);
      pulse_start(0);
      wait_done(1000);
    end
    rand_full = 0;
    rand_starve = 0;
    out_full = 1'b0;
    repeat (10) @(posedge clock);
    check("random done count", done_cnt - d0, 6);
    check("random input left", in_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
